// File: rtl/alu_flag_register.sv
// alu_flag_register: two-entry registered buffer for ALU results with sticky flags and op counter
// Ports: clk/rst (sync, active-high); in_valid/in_ready + in_opcode/in_result/in_{negative,overflow,zero,cout} (upstream);
//        out_valid/out_ready + out_opcode/out_result/out_flags {N,V,Z,C} (consumer);
//        clear_sticky, sticky_flags (OR of accepted flags), op_count (saturating push count).
// Define ALU_FLAG_COUNT_EN to implement op_count; otherwise op_count is tied to 0.
module alu_flag_register #(
  parameter int W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_opcode,
  input  logic [W-1:0]     in_result,
  input  logic             in_negative,
  input  logic             in_overflow,
  input  logic             in_zero,
  input  logic             in_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_opcode,
  output logic [W-1:0]     out_result,
  output logic [3:0]       out_flags,
  input  logic             clear_sticky,
  output logic [3:0]       sticky_flags,
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  localparam int EW = 2 * W + 4;
  state_t state_q, state_d;
  logic [EW-1:0] head_q, head_d, tail_q, tail_d, in_ent;
  logic [3:0] sticky_q, sticky_d, in_flags;
  logic push, pop;
  assign in_flags = {in_negative, in_overflow, in_zero, in_cout};
  assign in_ent = {in_opcode, in_result, in_flags};
  assign in_ready = state_q != TWO;
  assign out_valid = state_q != EMPTY;
  assign out_opcode = head_q[EW-1 -: W];
  assign out_result = head_q[W+3 -: W];
  assign out_flags = head_q[3:0];
  assign sticky_flags = sticky_q;
  always_comb begin
    push = in_valid && in_ready;
    pop = out_valid && out_ready;
    state_d = state_q == EMPTY ? (push ? ONE : EMPTY)
            : state_q == ONE   ? (push && !pop ? TWO : pop && !push ? EMPTY : ONE)
            :                    (pop ? ONE : TWO);
    // New entry goes straight to head when the buffer is empty or the head leaves this cycle
    head_d = push && (state_q == EMPTY || pop) ? in_ent
           : state_q == TWO && pop ? tail_q : head_q;
    tail_d = state_q == ONE && push && !pop ? in_ent : tail_q;
    sticky_d = clear_sticky ? (push ? in_flags : 4'b0)
             : push ? sticky_q | in_flags : sticky_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q <= '0;
      tail_q <= '0;
      sticky_q <= '0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      tail_q <= tail_d;
      sticky_q <= sticky_d;
    end
  end
`ifdef ALU_FLAG_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign op_count = cnt_q;
  always_comb cnt_d = push && cnt_q != '1 ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`else
  assign op_count = '0;
`endif
endmodule

// File: tb/tb_alu_flag_register.sv
// tb_alu_flag_register: directed and random checks of alu_flag_register against a queue model
module tb_alu_flag_register;
  localparam int W = 4;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_negative, in_overflow, in_zero, in_cout;
  logic out_valid, out_ready, clear_sticky;
  logic [W-1:0] in_opcode, in_result, out_opcode, out_result;
  logic [3:0] out_flags, sticky_flags;
  logic [CW-1:0] op_count;
  typedef struct packed {logic [3:0] op; logic [3:0] res; logic [3:0] fl;} ent_t;
  ent_t q[$];
  ent_t shown;
  logic [3:0] sticky;
  int cnt;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  alu_flag_register #(.W(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_result(in_result), .in_negative(in_negative),
    .in_overflow(in_overflow), .in_zero(in_zero), .in_cout(in_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_result(out_result), .out_flags(out_flags), .clear_sticky(clear_sticky),
    .sticky_flags(sticky_flags), .op_count(op_count)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic check_outs();
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("out_opcode", 32'(out_opcode), 32'(shown.op));
    chk("out_result", 32'(out_result), 32'(shown.res));
    chk("out_flags", 32'(out_flags), 32'(shown.fl));
    chk("sticky_flags", 32'(sticky_flags), 32'(sticky));
    chk("op_count", 32'(op_count), 32'(cnt));
  endtask
  task automatic step(input logic iv, input ent_t e, input logic ordy, input logic clr, input logic r);
    bit push, pop;
    rst = r;
    in_valid = iv;
    {in_opcode, in_result, in_negative, in_overflow, in_zero, in_cout} = e;
    out_ready = ordy;
    clear_sticky = clr;
    push = iv && q.size() < 2;
    pop = ordy && q.size() > 0;
    if (r) begin
      q.delete();
      sticky = 4'h0;
      cnt = 0;
      shown = '0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
      if (clr) sticky = push ? e.fl : 4'h0;
      else if (push) sticky = sticky | e.fl;
`ifdef ALU_FLAG_COUNT_EN
      if (push && cnt < (1 << CW) - 1) cnt = cnt + 1;
`endif
      if (q.size() > 0) shown = q[0];
    end
    @(posedge clk);
    @(negedge clk);
    check_outs();
  endtask
  function automatic ent_t rnd();
    return ent_t'($urandom_range(0, 4095));
  endfunction
  initial begin
    q.delete();
    shown = '0;
    sticky = 4'h0;
    cnt = 0;
    // reset during traffic
    step(1'b1, rnd(), 1'b0, 1'b0, 1'b0);
    step(1'b1, rnd(), 1'b0, 1'b0, 1'b0);
    step(1'b1, rnd(), 1'b1, 1'b1, 1'b1);
    step(1'b1, rnd(), 1'b1, 1'b0, 1'b1);
    step(1'b0, rnd(), 1'b0, 1'b0, 1'b0);
    // single entry
    step(1'b1, {4'h1, 4'h0, 4'b0011}, 1'b1, 1'b0, 1'b0);
    chk("single_flags", 32'(out_flags), 32'h3);
    step(1'b0, rnd(), 1'b1, 1'b0, 1'b0);
    chk("single_popped", 32'(out_valid), 32'h0);
    // backpressure and order
    step(1'b1, {4'h2, 4'h8, 4'b1000}, 1'b0, 1'b0, 1'b0);
    step(1'b1, {4'h3, 4'h3, 4'b0000}, 1'b0, 1'b0, 1'b0);
    chk("bp_full", 32'(in_ready), 32'h0);
    step(1'b1, {4'h4, 4'h5, 4'b0110}, 1'b0, 1'b0, 1'b0);
    step(1'b0, rnd(), 1'b1, 1'b0, 1'b0);
    chk("bp_second", 32'(out_result), 32'h3);
    step(1'b0, rnd(), 1'b1, 1'b0, 1'b0);
    // streaming after reset
    step(1'b0, rnd(), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, rnd(), 1'b1, 1'b0, 1'b0);
    step(1'b0, rnd(), 1'b1, 1'b0, 1'b0);
    // sticky flags
    step(1'b0, rnd(), 1'b1, 1'b1, 1'b0);
    step(1'b1, {4'h5, 4'h6, 4'b0100}, 1'b1, 1'b0, 1'b0);
    step(1'b1, {4'h6, 4'h7, 4'b0001}, 1'b1, 1'b1, 1'b0);
    chk("sticky_clear_push", 32'(sticky_flags), 32'h1);
    step(1'b0, rnd(), 1'b1, 1'b1, 1'b0);
    chk("sticky_clear", 32'(sticky_flags), 32'h0);
    // counter saturation
    for (int i = 0; i < 20; i++) step(1'b1, rnd(), 1'b1, 1'b0, 1'b0);
    // random traffic with occasional reset
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), rnd(), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 59) == 0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
